// File: rtl/arbiter_4to1_24bit.sv
// rtl/arbiter_4to1_24bit.sv - round-robin 4:1 arbiter with burst lock and registered valid/ready output
module arbiter_4to1_24bit #(
    parameter int WIDTH     = 24,
    parameter int MAX_BURST = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Req,
    input  logic [3:0]       Lock,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [WIDTH-1:0] In3,
    input  logic             OutReady,
    output logic [3:0]       Ack,
    output logic [1:0]       Select,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t           state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [3:0]       burst_cnt, burst_nxt, burst_inc;
    logic [WIDTH-1:0] out_q, out_nxt, win_data;
    logic [1:0]       winner, cand;
    logic             locked, load, any_req, grant;

    assign locked   = (state == LOCKED);
    assign OutValid = (state != IDLE);
    assign Out      = out_q;
    assign load     = !OutValid || OutReady;
    assign any_req  = |Req;
    assign grant    = load && any_req && !Reset;

    // Scan from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        winner = last;
        cand   = last;
        if (!(locked && Req[last])) begin
            for (int k = 4; k >= 1; k--) begin
                cand = last + 2'(k);
                if (Req[cand]) winner = cand;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_data = In0;
            2'd1:    win_data = In1;
            2'd2:    win_data = In2;
            default: win_data = In3;
        endcase
    end

    always_comb begin
        Ack = 4'b0000;
        if (grant) Ack[winner] = 1'b1;
    end

    always_comb begin
        if (Reset)      Select = 2'd0;
        else if (grant) Select = winner;
        else            Select = last;
    end

    assign burst_inc = (winner == last && locked) ? burst_cnt + 4'd1 : 4'd1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        out_nxt   = out_q;
        if (load) begin
            if (any_req) begin
                out_nxt   = win_data;
                last_nxt  = winner;
                burst_nxt = burst_inc;
                state_nxt = (Lock[winner] && (burst_inc < MAX_B)) ? LOCKED : FULL;
            end else begin
                // An idle cycle drops the lock; no reservation for the owner.
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            burst_cnt <= 4'd0;
            out_q     <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            out_q     <= out_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_4to1_24bit.sv
// tb/tb_arbiter_4to1_24bit.sv - directed and randomized bench for arbiter_4to1_24bit
module tb_arbiter_4to1_24bit;

    localparam int MAXB = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Req = 4'b0;
    logic [3:0]  Lock = 4'b0;
    logic [23:0] in_w [4];
    logic        OutReady = 1'b0;
    logic [3:0]  Ack;
    logic [1:0]  Select;
    logic [23:0] Out;
    logic        OutValid;

    int n_cmp = 0;
    int n_fail = 0;

    // reference state
    logic [23:0] m_out = '0;
    bit          m_valid = 0;
    int          m_last = 3;
    int          m_run = 0;
    bit          m_locked = 0;

    arbiter_4to1_24bit #(.WIDTH(24), .MAX_BURST(MAXB)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Lock(Lock),
        .In0(in_w[0]), .In1(in_w[1]), .In2(in_w[2]), .In3(in_w[3]),
        .OutReady(OutReady), .Ack(Ack), .Select(Select), .Out(Out), .OutValid(OutValid)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int model_winner();
        if (m_locked && Req[m_last]) return m_last;
        for (int k = 1; k <= 4; k++)
            if (Req[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            m_out = '0; m_valid = 0; m_last = 3; m_run = 0; m_locked = 0;
        end else if (!m_valid || OutReady) begin
            int w;
            w = model_winner();
            if (w >= 0) begin
                m_run    = (w == m_last && m_locked) ? m_run + 1 : 1;
                m_locked = Lock[w] && (m_run < MAXB);
                m_out    = in_w[w];
                m_valid  = 1;
                m_last   = w;
            end else begin
                m_valid  = 0;
                m_locked = 0;
            end
        end
    end

    always @(negedge Clock) begin
        logic [3:0] e_ack;
        int         e_sel;
        int         w;
        e_ack = 4'b0;
        e_sel = m_last;
        if (Reset) begin
            e_sel = 0;
        end else if (!m_valid || OutReady) begin
            w = model_winner();
            if (w >= 0) begin
                e_ack = 4'b0001 << w;
                e_sel = w;
            end
        end
        chk("ack", 32'(Ack), 32'(e_ack));
        chk("select", 32'(Select), 32'(e_sel));
        chk("out", 32'(Out), 32'(m_out));
        chk("outvalid", 32'(OutValid), 32'(m_valid));
    end

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Req = 4'b0; Lock = 4'b0; OutReady = 1'b1;
        next_cycle();
        Reset = 1'b0;
    endtask

    initial begin
        int g3 [10];
        g3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 4; i++) in_w[i] = 24'(i);

        // round robin over all four
        do_reset();
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            chk("t1_ack", 32'(Ack), 32'(4'b0001 << (k % 4)));
            if (k == 0) begin
                chk("reset_outvalid", 32'(OutValid), 32'd0);
                chk("reset_out", 32'(Out), 32'd0);
            end else begin
                chk("t1_out", 32'(Out), 32'((k - 1) % 4));
            end
            next_cycle();
        end

        // single requester
        do_reset();
        Req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            chk("t2_ack", 32'(Ack), 32'(4'b0100));
            chk("t2_sel", 32'(Select), 32'd2);
            if (k > 0) chk("t2_valid", 32'(OutValid), 32'd1);
            next_cycle();
        end

        // bounded burst lock
        do_reset();
        Req = 4'b0011; Lock = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            chk("t3_ack", 32'(Ack), 32'(4'b0001 << g3[k]));
            next_cycle();
        end

        // backpressure
        do_reset();
        for (int i = 0; i < 4; i++) in_w[i] = 24'hA0000 + 24'(i);
        Req = 4'b1111;
        @(negedge Clock);
        chk("t4_first_ack", 32'(Ack), 32'h1);
        next_cycle();
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            chk("t4_stall_ack", 32'(Ack), 32'h0);
            chk("t4_stall_out", 32'(Out), 32'hA0000);
            chk("t4_stall_valid", 32'(OutValid), 32'd1);
            next_cycle();
        end
        OutReady = 1'b1;
        @(negedge Clock);
        chk("t4_resume_ack", 32'(Ack), 32'h2);
        next_cycle();
        @(negedge Clock);
        chk("t4_resume_out", 32'(Out), 32'hA0001);
        next_cycle();

        // locked owner drops request
        do_reset();
        Req = 4'b0010; Lock = 4'b0010;
        @(negedge Clock);
        chk("t5_lock_ack", 32'(Ack), 32'h2);
        next_cycle();
        Req = 4'b1100;
        @(negedge Clock);
        chk("t5_drop_ack", 32'(Ack), 32'h4);
        next_cycle();
        Lock = 4'b0; Req = 4'b1110;
        @(negedge Clock);
        chk("t5_rotate_ack", 32'(Ack), 32'h8);
        next_cycle();

        // reset mid-burst
        do_reset();
        Req = 4'b0001; Lock = 4'b0001;
        next_cycle();
        next_cycle();
        Reset = 1'b1;
        @(negedge Clock);
        chk("t6_rst_ack", 32'(Ack), 32'h0);
        chk("t6_rst_sel", 32'(Select), 32'h0);
        next_cycle();
        Reset = 1'b0; Req = 4'b1111; Lock = 4'b0;
        @(negedge Clock);
        chk("t6_outvalid", 32'(OutValid), 32'd0);
        chk("t6_out", 32'(Out), 32'd0);
        chk("t6_first_ack", 32'(Ack), 32'h1);
        next_cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Reset    = ($urandom_range(0, 99) == 0);
            Req      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 15));
            Lock     = 4'($urandom_range(0, 15));
            OutReady = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) in_w[i] = 24'($urandom);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
